stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of pushed data word.
REQ-002 SHALL have parameter STACK_DEPTH, default 16: entry count of the attached memory array; legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_edge  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port push_req  input  1  request to push wr_data.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  data to push, sampled with push_req.
REQ-007 SHALL have port pop_req  input  1  request to pop top entry.
REQ-008 SHALL have port multi_req  input  1  request to read top rd_cnt entries without popping.
REQ-009 SHALL have port rd_cnt  input  4  entry count for multi_req, sampled with it.
REQ-010 SHALL have ports sp  output  8, stack_push  output  1, stack_pop  output  1, stack_citajVise  output  1, mem_wdata  output  DATA_WIDTH: registered memory-array control (address, write strobe, pop-read strobe, multi-read strobe, write data).
REQ-011 SHALL have ports full, empty, busy, rd_valid, overflow, underflow, each output 1: status, read-data-valid strobe, and error flags.

Function
REQ-012 SHALL keep count (0..STACK_DEPTH); full = (count==STACK_DEPTH), empty = (count==0), both combinational from count.
REQ-013 SHALL sample requests only when busy==0; while busy==1, requests SHALL be ignored with no flag, no queueing.
REQ-014 SHALL resolve simultaneous requests by priority pop > push > multi; losers ignored.
REQ-015 Push accepted (not full): next cycle stack_push=1 for 1 cycle, sp=old count, mem_wdata=wr_data; count increments; busy stays 0.
REQ-016 Pop accepted (not empty): next cycle (C1) stack_pop=1 for 1 cycle, sp=old count-1, count decrements; sp SHALL hold C1..C2; busy=1 in C1 only; rd_valid=1 in C3 only.
REQ-017 Multi accepted (1<=rd_cnt<=count, N=rd_cnt, T=count-1): stack_citajVise=1 in C1..CN; sp=T in C1 and C2, then T-1 in C3 ... T-N+1 in C(N+1); rd_valid=1 in C3..C(N+2); busy=1 in C1..C(N+1); count unchanged.
REQ-018 States SHALL be IDLE, POP_HOLD, MULTI; IDLE->POP_HOLD on pop accept, POP_HOLD->IDLE after 1 cycle; IDLE->MULTI on multi accept, MULTI->IDLE when sp reaches T-N+1 phase end.
REQ-019 Push when full SHALL produce overflow=1 for 1 cycle; no strobe, count/sp unchanged.
REQ-020 Pop when empty, or multi with rd_cnt==0 or rd_cnt>count, SHALL produce underflow=1 for 1 cycle; no strobe, state stays IDLE.
REQ-021 sp SHALL hold its last value when no operation is active; sp arithmetic SHALL never wrap (guarded by REQ-019/020).

Reset
REQ-022 rst_edge=1 SHALL set count=0, sp=0, mem_wdata=0, all strobes 0, busy=0, rd_valid=0, overflow=0, underflow=0, state IDLE, on the next edge.
REQ-023 Reset during POP_HOLD or MULTI SHALL abort the operation; no further strobe or rd_valid SHALL follow; memory contents are not cleared.

Configuration
REQ-024 With STACK_STICKY_ERR_EN defined, overflow and underflow SHALL be sticky (held 1 until rst_edge); without it they SHALL be single-cycle pulses per REQ-019/020.

Verification
REQ-025 Reset, push 0x3,0x7,0x9 -> stack_push pulses with sp=0,1,2, mem_wdata=3,7,9; count=3, empty=0.
REQ-026 From REQ-025 state, pop -> stack_pop pulse sp=2, busy 1 cycle, rd_valid in C3, count=2.
REQ-027 Push 16 entries then push again -> full=1, overflow pulse (sticky with STACK_STICKY_ERR_EN), no stack_push, sp=15.
REQ-028 count=5, multi rd_cnt=3 -> stack_citajVise C1..C3, sp=4,4,3,2 in C1..C4, rd_valid C3..C5, busy C1..C4, count=5.
REQ-029 Empty, pop -> underflow; count=2, multi rd_cnt=3 -> underflow; simultaneous pop+push with count=1 -> pop only, count=0.
REQ-030 rst_edge asserted in C2 of multi rd_cnt=4 -> all strobes 0, rd_valid never asserts after, count=0, sp=0.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Request/response bundle between a stack client and stack_ctrl.
// The master drives requests; the slave returns memory-array control and status.
interface stack_ctrl_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  push_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  pop_req;
  logic                  multi_req;
  logic [3:0]            rd_cnt;
  logic [7:0]            sp;
  logic                  stack_push;
  logic                  stack_pop;
  logic                  stack_citajVise;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  full;
  logic                  empty;
  logic                  busy;
  logic                  rd_valid;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push_req, wr_data, pop_req, multi_req, rd_cnt,
    input  sp, stack_push, stack_pop, stack_citajVise, mem_wdata,
    input  full, empty, busy, rd_valid, overflow, underflow
  );

  modport slave (
    input  push_req, wr_data, pop_req, multi_req, rd_cnt,
    output sp, stack_push, stack_pop, stack_citajVise, mem_wdata,
    output full, empty, busy, rd_valid, overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack pointer / strobe controller for an external memory array (push, pop, multi-read).
// Define STACK_STICKY_ERR_EN to make overflow/underflow sticky until reset.
module stack_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 16
) (
  input logic      clk,
  input logic      rst_edge,
  stack_ctrl_if.slave bus
);

`ifdef STACK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [7:0] DEPTH = 8'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, POP_HOLD, MULTI} state_t;

  state_t                state;
  logic [7:0]            count;
  logic [7:0]            sp;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  stack_push;
  logic                  stack_pop;
  logic                  citaj;
  logic                  busy;
  logic                  rd_stage;
  logic                  rd_valid;
  logic                  overflow;
  logic                  underflow;
  logic [3:0]            n_cnt;
  logic [4:0]            phase;

  logic full, empty;
  logic pop_sel, push_sel, multi_sel;
  logic pop_ok, pop_bad, push_ok, push_bad, multi_ok, multi_bad;

  assign full  = (count == DEPTH);
  assign empty = (count == 8'd0);

  // Requests are only looked at while idle; pop beats push beats multi.
  assign pop_sel   = !busy && bus.pop_req;
  assign push_sel  = !busy && !bus.pop_req && bus.push_req;
  assign multi_sel = !busy && !bus.pop_req && !bus.push_req && bus.multi_req;

  assign pop_ok    = pop_sel && !empty;
  assign pop_bad   = pop_sel && empty;
  assign push_ok   = push_sel && !full;
  assign push_bad  = push_sel && full;
  assign multi_ok  = multi_sel && (bus.rd_cnt != 4'd0) && ({4'd0, bus.rd_cnt} <= count);
  assign multi_bad = multi_sel && !multi_ok;

  // Read data trails each pop/multi-read strobe by two cycles, hence the two-stage rd pipe.
  always_ff @(posedge clk) begin
    if (rst_edge) begin
      state      <= IDLE;
      count      <= 8'd0;
      sp         <= 8'd0;
      mem_wdata  <= '0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      citaj      <= 1'b0;
      busy       <= 1'b0;
      rd_stage   <= 1'b0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      n_cnt      <= 4'd0;
      phase      <= 5'd0;
    end else begin
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      citaj      <= 1'b0;
      rd_stage   <= stack_pop | citaj;
      rd_valid   <= rd_stage;
      overflow   <= push_bad | (STICKY & overflow);
      underflow  <= pop_bad | multi_bad | (STICKY & underflow);

      case (state)
        IDLE: begin
          if (pop_ok) begin
            stack_pop <= 1'b1;
            sp        <= count - 8'd1;
            count     <= count - 8'd1;
            busy      <= 1'b1;
            state     <= POP_HOLD;
          end else if (push_ok) begin
            stack_push <= 1'b1;
            sp         <= count;
            mem_wdata  <= bus.wr_data;
            count      <= count + 8'd1;
          end else if (multi_ok) begin
            citaj <= 1'b1;
            sp    <= count - 8'd1;
            busy  <= 1'b1;
            n_cnt <= bus.rd_cnt;
            phase <= 5'd1;
            state <= MULTI;
          end
        end

        POP_HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        // phase k is the k-th cycle after acceptance; sp holds top for two cycles, then walks down.
        MULTI: begin
          if (phase == ({1'b0, n_cnt} + 5'd1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            phase <= phase + 5'd1;
            citaj <= (phase < {1'b0, n_cnt});
            if (phase >= 5'd2) sp <= sp - 8'd1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sp              = sp;
  assign bus.stack_push      = stack_push;
  assign bus.stack_pop       = stack_pop;
  assign bus.stack_citajVise = citaj;
  assign bus.mem_wdata       = mem_wdata;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.busy            = busy;
  assign bus.rd_valid        = rd_valid;
  assign bus.overflow        = overflow;
  assign bus.underflow       = underflow;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a behavioural model queues per-cycle expected outputs
// when a request is driven, and they are popped and compared on each falling edge.
module tb_stack_ctrl;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_edge;

  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  stack_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_edge (rst_edge),
    .bus      (bus)
  );

  typedef struct {
    logic          push;
    logic          pop;
    logic          multi;
    logic [7:0]    sp;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          rdv;
    logic          ovf;
    logic          unf;
    logic          full;
    logic          empty;
  } exp_t;

  exp_t          expq[$];
  int            total = 0;
  int            bad   = 0;
  int            cnt_m;
  logic [7:0]    sp_m;
  logic [DW-1:0] wd_m;
  bit            ovf_st;
  bit            unf_st;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
    end
  endtask

  function automatic exp_t idleExp();
    exp_t e;
    e.push  = 1'b0;
    e.pop   = 1'b0;
    e.multi = 1'b0;
    e.sp    = sp_m;
    e.wdata = wd_m;
    e.busy  = 1'b0;
    e.rdv   = 1'b0;
    e.ovf   = 1'b0;
    e.unf   = 1'b0;
    e.full  = (cnt_m == DEPTH);
    e.empty = (cnt_m == 0);
    return e;
  endfunction

  function automatic void addExp(exp_t e);
    exp_t x = e;
`ifdef STACK_STICKY_ERR_EN
    x.ovf = x.ovf | ovf_st;
    x.unf = x.unf | unf_st;
`endif
    expq.push_back(x);
  endfunction

  function automatic void modelReset();
    cnt_m  = 0;
    sp_m   = 8'd0;
    wd_m   = '0;
    ovf_st = 1'b0;
    unf_st = 1'b0;
    expq.delete();
  endfunction

  // Expected outputs for cycles C1.. following a request sampled at one rising edge.
  function automatic void buildExpect(bit p_push, bit p_pop, bit p_multi,
                                      logic [DW-1:0] d, logic [3:0] n);
    exp_t e;
    int   t;
    int   nn;
    if (p_pop) begin
      if (cnt_m == 0) begin
        unf_st = 1'b1;
        e = idleExp(); e.unf = 1'b1; addExp(e);
        addExp(idleExp());
      end else begin
        cnt_m = cnt_m - 1;
        sp_m  = 8'(cnt_m);
        e = idleExp(); e.pop = 1'b1; e.busy = 1'b1; addExp(e);
        addExp(idleExp());
        e = idleExp(); e.rdv = 1'b1; addExp(e);
        addExp(idleExp());
      end
    end else if (p_push) begin
      if (cnt_m == DEPTH) begin
        ovf_st = 1'b1;
        e = idleExp(); e.ovf = 1'b1; addExp(e);
        addExp(idleExp());
      end else begin
        sp_m  = 8'(cnt_m);
        wd_m  = d;
        cnt_m = cnt_m + 1;
        e = idleExp(); e.push = 1'b1; addExp(e);
        addExp(idleExp());
      end
    end else if (p_multi) begin
      nn = int'(n);
      if (nn == 0 || nn > cnt_m) begin
        unf_st = 1'b1;
        e = idleExp(); e.unf = 1'b1; addExp(e);
        addExp(idleExp());
      end else begin
        t = cnt_m - 1;
        for (int c = 1; c <= nn + 3; c++) begin
          if (c <= 2)           sp_m = 8'(t);
          else if (c <= nn + 1) sp_m = 8'(t - (c - 2));
          else                  sp_m = 8'(t - nn + 1);
          e = idleExp();
          e.multi = (c <= nn);
          e.busy  = (c <= nn + 1);
          e.rdv   = (c >= 3) && (c <= nn + 2);
          addExp(e);
        end
      end
    end else begin
      addExp(idleExp());
    end
  endfunction

  task automatic drain();
    exp_t e;
    while (expq.size() > 0) begin
      @(negedge clk);
      e = expq.pop_front();
      checkOutput("stack_push", int'(bus.stack_push), int'(e.push));
      checkOutput("stack_pop", int'(bus.stack_pop), int'(e.pop));
      checkOutput("stack_citajVise", int'(bus.stack_citajVise), int'(e.multi));
      checkOutput("sp", int'(bus.sp), int'(e.sp));
      checkOutput("mem_wdata", int'(bus.mem_wdata), int'(e.wdata));
      checkOutput("busy", int'(bus.busy), int'(e.busy));
      checkOutput("rd_valid", int'(bus.rd_valid), int'(e.rdv));
      checkOutput("overflow", int'(bus.overflow), int'(e.ovf));
      checkOutput("underflow", int'(bus.underflow), int'(e.unf));
      checkOutput("full", int'(bus.full), int'(e.full));
      checkOutput("empty", int'(bus.empty), int'(e.empty));
    end
  endtask

  // poke raises every request during C1, where busy must make them invisible.
  task automatic driveReq(bit p_push, bit p_pop, bit p_multi,
                          logic [DW-1:0] d, logic [3:0] n, bit poke);
    bus.push_req  = p_push;
    bus.pop_req   = p_pop;
    bus.multi_req = p_multi;
    bus.wr_data   = d;
    bus.rd_cnt    = n;
    @(posedge clk);
    #1;
    bus.push_req  = 1'b0;
    bus.pop_req   = 1'b0;
    bus.multi_req = 1'b0;
    if (poke) begin
      bus.push_req  = 1'b1;
      bus.pop_req   = 1'b1;
      bus.multi_req = 1'b1;
      bus.wr_data   = 4'hA;
      bus.rd_cnt    = 4'd1;
      @(posedge clk);
      #1;
      bus.push_req  = 1'b0;
      bus.pop_req   = 1'b0;
      bus.multi_req = 1'b0;
    end
  endtask

  task automatic applyStimulus(bit p_push, bit p_pop, bit p_multi,
                               logic [DW-1:0] d, logic [3:0] n, bit poke);
    buildExpect(p_push, p_pop, p_multi, d, n);
    fork
      driveReq(p_push, p_pop, p_multi, d, n, poke);
      drain();
    join
  endtask

  task automatic resetDut();
    rst_edge = 1'b1;
    @(posedge clk);
    #1;
    rst_edge = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) addExp(idleExp());
    drain();
  endtask

  initial begin
    bus.push_req  = 1'b0;
    bus.pop_req   = 1'b0;
    bus.multi_req = 1'b0;
    bus.wr_data   = '0;
    bus.rd_cnt    = 4'd0;
    rst_edge      = 1'b1;
    modelReset();

    $display("[TB] reset and basic pushes");
    resetDut();
    applyStimulus(1, 0, 0, 4'h3, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'h7, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'h9, 4'd0, 0);
    applyStimulus(0, 1, 0, 4'h0, 4'd0, 1);

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < 14; i++) applyStimulus(1, 0, 0, 4'($urandom_range(0, 15)), 4'd0, 0);
    applyStimulus(1, 0, 0, 4'hC, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'hD, 4'd0, 0);

    $display("[TB] pops down to five, multi-reads");
    for (int i = 0; i < 11; i++) applyStimulus(0, 1, 0, 4'h0, 4'd0, (i == 0));
    applyStimulus(0, 0, 1, 4'h0, 4'd3, 1);
    applyStimulus(0, 0, 1, 4'h0, 4'd0, 0);
    applyStimulus(0, 0, 1, 4'h0, 4'd6, 0);
    applyStimulus(0, 0, 1, 4'h0, 4'd5, 0);
    applyStimulus(0, 0, 1, 4'h0, 4'd1, 0);

    $display("[TB] underflow and priority cases");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'h0, 4'd0, 0);
    applyStimulus(0, 0, 1, 4'h0, 4'd3, 0);
    applyStimulus(0, 1, 0, 4'h0, 4'd0, 0);
    applyStimulus(1, 1, 1, 4'h6, 4'd1, 0);
    applyStimulus(0, 1, 0, 4'h0, 4'd0, 0);
    applyStimulus(1, 0, 1, 4'h5, 4'd1, 0);

    $display("[TB] reset during multi-read");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 4'(i + 1), 4'd0, 0);
    buildExpect(0, 0, 1, 4'h0, 4'd4);
    while (expq.size() > 2) void'(expq.pop_back());
    fork
      driveReq(0, 0, 1, 4'h0, 4'd4, 0);
      drain();
    join
    resetDut();
    applyStimulus(1, 0, 0, 4'hB, 4'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
